param_type_selector: RTL and testbench
======================================

// Module: param_type_selector
// PURPOSE
//   Front-panel stage feeding the 4-bit paramType PIO (in_port) read by the Nios CPU.
//   Debounces two active-low push-buttons (NEXT/PREV) and steps a wrapping parameter-type
//   index (decay, predelay, mix, ...) that selects which reverb parameter the encoder edits.
//   Emits a one-cycle change strobe for optional IRQ/edge-capture use.
// PARAMETERS
//   NUM_PARAMS       6        number of valid parameter types; legal range 2..16
//   DEBOUNCE_CYCLES  500000   consecutive stable clocks needed to accept a key level (10 ms @ 50 MHz)
//   CNT_W            20       debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
// PORTS
//   clk            in   1  system clock (50 MHz audio/control domain)
//   reset_n        in   1  asynchronous active-low reset
//   key_next_n     in   1  NEXT push-button, active-low, asynchronous to clk
//   key_prev_n     in   1  PREV push-button, active-low, asynchronous to clk
//   param_type     out  4  current parameter-type index, 0..NUM_PARAMS-1; drives paramType PIO in_port
//   param_changed  out  1  one-cycle pulse, asserted in the same cycle param_type takes its new value
// BEHAVIOUR
//   Clocking: single clock domain; reset is asynchronous, active-low.
//   - Reset values: param_type=0, param_changed=0, sync flops=1, key FSMs=RELEASED, counters=0.
//   - Sync: each key passes through a 2-FF synchroniser (reset to 1); only the 2nd FF is used.
//   - Per-key FSM states: RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND.
//       RELEASED     : sync==0 -> PRESS_PEND, cnt=1.
//       PRESS_PEND   : sync==1 -> RELEASED, cnt=0 (glitch rejected).
//                      sync==0 && cnt==DEBOUNCE_CYCLES-1 -> PRESSED, cnt=0, press pulse=1 for one cycle.
//                      else cnt++.
//       PRESSED      : sync==1 -> RELEASE_PEND, cnt=1.
//       RELEASE_PEND : sync==0 -> PRESSED, cnt=0.
//                      sync==1 && cnt==DEBOUNCE_CYCLES-1 -> RELEASED, cnt=0.
//                      else cnt++.
//   - Only the press transition generates an event; holding a key never auto-repeats.
//   - Index update, registered, one cycle after the press pulse:
//       next only : idx==NUM_PARAMS-1 ? 0 : idx+1.
//       prev only : idx==0 ? NUM_PARAMS-1 : idx-1.
//       both pulses in the same cycle : no change, no strobe.
//   - param_changed=1 exactly in the cycle the index changes; otherwise 0.
//   - Latency: a clean pin edge produces a param_type change exactly DEBOUNCE_CYCLES+3 clocks later
//     (2 sync + DEBOUNCE_CYCLES pending + 1 update).
//   - param_type[3:NUM_PARAMS-width] is zero-extended; the index never leaves 0..NUM_PARAMS-1.
//   - reset_n asserted mid-press or mid-count: everything returns to reset values immediately.
//     After release of reset, a key still held low must be re-debounced and then counts as a
//     new press.
//   - Counter arithmetic is unsigned CNT_W bits and saturates by construction (FSM exits at the limit).
// STRUCTURE
//   - Shared package reverb_ctrl_pkg:
//       PARAM_TYPE_W=4
//       codes PT_DECAY=0, PT_PREDELAY=1, PT_MIX=2, PT_DAMPING=3, PT_DIFFUSION=4, PT_ROOMSIZE=5
//       key FSM state encoding
//   - Sub-module key_debouncer (sync + FSM + counter; outputs press pulse and level):
//       instantiated twice, for NEXT and PREV.
//   - Top level holds only the wrapping index register and the strobe.
// TESTING  (bench uses DEBOUNCE_CYCLES=8, NUM_PARAMS=6)
//   1. Reset, keys high -> param_type=0, param_changed=0.
//      Hold reset 5 clks with keys toggling -> outputs stay 0.
//   2. NEXT low at clk 0, held 20 clks -> param_type 0->1 at clk 11; param_changed high clk 11 only.
//      No further change while held.
//   3. NEXT low for 5 clks then high (glitch) -> no change.
//      NEXT bouncing 3 times within 6 clks, then stable low -> exactly one increment.
//   4. Six clean NEXT presses from 0 -> 1,2,3,4,5,0 (wrap).
//      PREV press at 0 -> 5.
//   5. NEXT and PREV pressed on the same clk, both held -> both pulses coincide;
//      param_type unchanged, no strobe.
//   6. NEXT held; reset_n pulsed at clk 6 of pending count; NEXT still held ->
//      param_type=0 after reset, then becomes 1 exactly 11 clks after reset release.

Source files
------------

// File: rtl/param_type_selector_pkg.sv
// Shared reverb front-panel definitions: parameter-type codes, index width,
// and the per-key debounce FSM state encoding.
package reverb_ctrl_pkg;

    localparam int unsigned PARAM_TYPE_W = 4;

    // Parameter-type codes presented to the CPU through the paramType PIO
    localparam logic [PARAM_TYPE_W-1:0] PT_DECAY     = 4'd0;
    localparam logic [PARAM_TYPE_W-1:0] PT_PREDELAY  = 4'd1;
    localparam logic [PARAM_TYPE_W-1:0] PT_MIX       = 4'd2;
    localparam logic [PARAM_TYPE_W-1:0] PT_DAMPING   = 4'd3;
    localparam logic [PARAM_TYPE_W-1:0] PT_DIFFUSION = 4'd4;
    localparam logic [PARAM_TYPE_W-1:0] PT_ROOMSIZE  = 4'd5;

    typedef enum logic [1:0] {
        KEY_RELEASED     = 2'd0,
        KEY_PRESS_PEND   = 2'd1,
        KEY_PRESSED      = 2'd2,
        KEY_RELEASE_PEND = 2'd3
    } key_state_e;

endpackage

// File: rtl/param_type_selector_if.sv
// Front-panel bundle: two active-low push-buttons in, parameter-type index
// and change strobe out.
//   master : drives the keys, observes param_type / param_changed
//   slave  : the selector itself
interface param_type_selector_if;
    import reverb_ctrl_pkg::*;

    logic                    key_next_n;
    logic                    key_prev_n;
    logic [PARAM_TYPE_W-1:0] param_type;
    logic                    param_changed;

    modport master (
        output key_next_n,
        output key_prev_n,
        input  param_type,
        input  param_changed
    );

    modport slave (
        input  key_next_n,
        input  key_prev_n,
        output param_type,
        output param_changed
    );
endinterface

// File: rtl/param_type_selector_key_debouncer.sv
// Single push-button conditioner: 2-FF synchroniser followed by a
// four-state debounce FSM. Emits a one-cycle press pulse when a low level
// has been stable for DEBOUNCE_CYCLES clocks; releases never produce events.
//   clk, reset_n : clock, async active-low reset
//   key_n        : raw active-low button, asynchronous to clk
//   press        : registered one-cycle pulse on an accepted press
module key_debouncer
    import reverb_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             sync_1;
    logic             sync_2;
    key_state_e       state_q;
    key_state_e       state_nx;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nx;
    logic             press_nx;

    // Synchroniser resets to the idle (released) level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= key_n;
            sync_2 <= sync_1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= KEY_RELEASED;
            cnt_q   <= '0;
            press   <= 1'b0;
        end else begin
            state_q <= state_nx;
            cnt_q   <= cnt_nx;
            press   <= press_nx;
        end
    end

    // Next-state / counter; the counter never passes CNT_LIM because both
    // pending states leave as soon as it is reached.
    always_comb begin
        state_nx = state_q;
        cnt_nx   = cnt_q;
        press_nx = 1'b0;
        case (state_q)
            KEY_RELEASED: begin
                if (!sync_2) begin
                    state_nx = KEY_PRESS_PEND;
                    cnt_nx   = CNT_ONE;
                end
            end
            KEY_PRESS_PEND: begin
                if (sync_2) begin
                    state_nx = KEY_RELEASED;
                    cnt_nx   = '0;
                end else if (cnt_q == CNT_LIM) begin
                    state_nx = KEY_PRESSED;
                    cnt_nx   = '0;
                    press_nx = 1'b1;
                end else begin
                    cnt_nx = cnt_q + CNT_ONE;
                end
            end
            KEY_PRESSED: begin
                if (sync_2) begin
                    state_nx = KEY_RELEASE_PEND;
                    cnt_nx   = CNT_ONE;
                end
            end
            KEY_RELEASE_PEND: begin
                if (!sync_2) begin
                    state_nx = KEY_PRESSED;
                    cnt_nx   = '0;
                end else if (cnt_q == CNT_LIM) begin
                    state_nx = KEY_RELEASED;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_nx = KEY_RELEASED;
                cnt_nx   = '0;
            end
        endcase
    end

endmodule

// File: rtl/param_type_selector.sv
// Reverb front-panel parameter-type selector. Two debounced buttons step a
// wrapping index 0..NUM_PARAMS-1 that feeds the paramType PIO; a one-cycle
// strobe marks every change.
//   clk, reset_n : clock, async active-low reset
//   bus (slave)  : key_next_n, key_prev_n in; param_type, param_changed out
module param_type_selector
    import reverb_ctrl_pkg::*;
#(
    parameter int unsigned NUM_PARAMS      = 6,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic                   clk,
    input  logic                   reset_n,
    param_type_selector_if.slave   bus
);

    localparam logic [PARAM_TYPE_W-1:0] IDX_LAST = PARAM_TYPE_W'(NUM_PARAMS - 1);
    localparam logic [PARAM_TYPE_W-1:0] IDX_ONE  = PARAM_TYPE_W'(1);

    logic                    press_next;
    logic                    press_prev;
    logic [PARAM_TYPE_W-1:0] idx_q;
    logic [PARAM_TYPE_W-1:0] idx_nx;
    logic                    changed_q;
    logic                    changed_nx;

    key_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_next (
        .clk     (clk),
        .reset_n (reset_n),
        .key_n   (bus.key_next_n),
        .press   (press_next)
    );

    key_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_prev (
        .clk     (clk),
        .reset_n (reset_n),
        .key_n   (bus.key_prev_n),
        .press   (press_prev)
    );

    // Wrapping step; simultaneous NEXT and PREV presses cancel out
    always_comb begin
        idx_nx     = idx_q;
        changed_nx = 1'b0;
        if (press_next && !press_prev) begin
            idx_nx     = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_ONE;
            changed_nx = 1'b1;
        end else if (press_prev && !press_next) begin
            idx_nx     = (idx_q == '0) ? IDX_LAST : idx_q - IDX_ONE;
            changed_nx = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q     <= '0;
            changed_q <= 1'b0;
        end else begin
            idx_q     <= idx_nx;
            changed_q <= changed_nx;
        end
    end

    assign bus.param_type    = idx_q;
    assign bus.param_changed = changed_q;

endmodule

// File: tb/tb_param_type_selector.sv
// Directed bench for param_type_selector with DEBOUNCE_CYCLES=8, NUM_PARAMS=6.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_param_type_selector;

    localparam int unsigned DEB = 8;
    localparam int unsigned NP  = 6;
    localparam int unsigned LAT = DEB + 3;

    logic clk;
    logic reset_n;
    int   vectors;
    int   miscompares;

    param_type_selector_if bus ();

    param_type_selector #(
        .NUM_PARAMS      (NP),
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (4)
    ) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clean press of a single key; change lands exactly LAT clocks after the pin edge
    task automatic clean_press(input bit is_next, input int exp_idx);
        if (is_next) bus.key_next_n = 1'b0;
        else         bus.key_prev_n = 1'b0;
        tick(LAT - 1);
        check("press_before_lat", 32'(bus.param_changed), 32'd0);
        tick(1);
        check("press_idx", 32'(bus.param_type), 32'(exp_idx));
        check("press_strobe", 32'(bus.param_changed), 32'd1);
        bus.key_next_n = 1'b1;
        bus.key_prev_n = 1'b1;
        tick(1);
        check("press_strobe_end", 32'(bus.param_changed), 32'd0);
        tick(LAT + 2);
    endtask

    initial begin
        int pulses;
        vectors        = 0;
        miscompares    = 0;
        reset_n        = 1'b0;
        bus.key_next_n = 1'b1;
        bus.key_prev_n = 1'b1;

        // 1. Reset behaviour, including keys toggling under reset
        tick(2);
        check("rst_idx", 32'(bus.param_type), 32'd0);
        check("rst_strobe", 32'(bus.param_changed), 32'd0);
        for (int i = 0; i < 5; i++) begin
            bus.key_next_n = i[0];
            bus.key_prev_n = ~i[0];
            tick(1);
            check("rst_hold_idx", 32'(bus.param_type), 32'd0);
            check("rst_hold_strobe", 32'(bus.param_changed), 32'd0);
        end
        bus.key_next_n = 1'b1;
        bus.key_prev_n = 1'b1;
        reset_n        = 1'b1;
        tick(LAT + 2);
        check("post_rst_idx", 32'(bus.param_type), 32'd0);

        // 2. NEXT held 20 clocks: single step at clock 11, no auto-repeat
        bus.key_next_n = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            check("hold_idx", 32'(bus.param_type), (k >= 11) ? 32'd1 : 32'd0);
            check("hold_strobe", 32'(bus.param_changed), (k == 11) ? 32'd1 : 32'd0);
        end
        bus.key_next_n = 1'b1;
        tick(LAT + 2);
        check("hold_release_idx", 32'(bus.param_type), 32'd1);

        // 3a. 5-clock glitch is rejected
        pulses = 0;
        bus.key_next_n = 1'b0;
        tick(5);
        bus.key_next_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            pulses += int'(bus.param_changed);
        end
        check("glitch_pulses", 32'(pulses), 32'd0);
        check("glitch_idx", 32'(bus.param_type), 32'd1);

        // 3b. Three bounces in 6 clocks then stable low: one increment
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            bus.key_next_n = k[0];
            tick(1);
            pulses += int'(bus.param_changed);
        end
        bus.key_next_n = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick(1);
            pulses += int'(bus.param_changed);
        end
        check("bounce_pulses", 32'(pulses), 32'd1);
        check("bounce_idx", 32'(bus.param_type), 32'd2);
        bus.key_next_n = 1'b1;
        tick(LAT + 2);

        // 4. Back to 0 with PREV, six NEXT presses wrap, PREV at 0 wraps to 5
        clean_press(1'b0, 1);
        clean_press(1'b0, 0);
        for (int n = 1; n <= 6; n++) clean_press(1'b1, n % 6);
        clean_press(1'b0, 5);

        // 5. Simultaneous NEXT and PREV: no change, no strobe
        pulses = 0;
        bus.key_next_n = 1'b0;
        bus.key_prev_n = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            pulses += int'(bus.param_changed);
        end
        check("both_pulses", 32'(pulses), 32'd0);
        check("both_idx", 32'(bus.param_type), 32'd5);
        bus.key_next_n = 1'b1;
        bus.key_prev_n = 1'b1;
        tick(LAT + 2);
        check("both_release_idx", 32'(bus.param_type), 32'd5);

        // 6. Reset mid-count with NEXT held: re-debounced as a fresh press
        bus.key_next_n = 1'b0;
        tick(6);
        reset_n = 1'b0;
        #1;
        check("midrst_idx", 32'(bus.param_type), 32'd0);
        check("midrst_strobe", 32'(bus.param_changed), 32'd0);
        tick(2);
        reset_n = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            tick(1);
            check("midrst_after_idx", 32'(bus.param_type), (k >= 11) ? 32'd1 : 32'd0);
            check("midrst_after_strobe", 32'(bus.param_changed), (k == 11) ? 32'd1 : 32'd0);
        end
        bus.key_next_n = 1'b1;
        tick(LAT + 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
